// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution tap sequencer.
package conv_pkg;

  localparam int unsigned DEF_IMG_W  = 8;
  localparam int unsigned DEF_IMG_H  = 8;
  localparam int unsigned DEF_K      = 3;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_PROD_W = 20;

  // Window coordinates travel the pipeline at this fixed width.
  localparam int unsigned COORD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic               valid;
    logic               first;
    logic               last;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } tag_t;

  // Bit width for an index range of v entries, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Nested window/tap counters with pixel and weight address generation.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned K     = DEF_K,
  localparam int unsigned AW   = clog2_min1(IMG_W * IMG_H),
  localparam int unsigned KAW  = clog2_min1(K * K),
  localparam int unsigned RW   = clog2_min1(IMG_H),
  localparam int unsigned CW   = clog2_min1(IMG_W),
  localparam int unsigned KW   = clog2_min1(K)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_step,
  output logic [AW-1:0]  o_img_addr,
  output logic [KAW-1:0] o_w_addr,
  output logic [RW-1:0]  o_row,
  output logic [CW-1:0]  o_col,
  output logic           o_first,
  output logic           o_last,
  output logic           o_final
);

  logic [RW-1:0] r_wr;
  logic [CW-1:0] r_wc;
  logic [KW-1:0] r_ki;
  logic [KW-1:0] r_kj;

  logic w_kj_end;
  logic w_ki_end;
  logic w_wc_end;
  logic w_wr_end;

  assign w_kj_end = (r_kj == KW'(K - 1));
  assign w_ki_end = (r_ki == KW'(K - 1));
  assign w_wc_end = (r_wc == CW'(IMG_W - K));
  assign w_wr_end = (r_wr == RW'(IMG_H - K));

  // Advance kj fastest, then ki, wc, wr; everything wraps to 0 after the final tap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_wc <= '0;
      r_ki <= '0;
      r_kj <= '0;
    end else if (i_step) begin
      if (w_kj_end) begin
        r_kj <= '0;
        if (w_ki_end) begin
          r_ki <= '0;
          if (w_wc_end) begin
            r_wc <= '0;
            if (w_wr_end) r_wr <= '0;
            else          r_wr <= r_wr + 1'b1;
          end else begin
            r_wc <= r_wc + 1'b1;
          end
        end else begin
          r_ki <= r_ki + 1'b1;
        end
      end else begin
        r_kj <= r_kj + 1'b1;
      end
    end
  end

  assign o_img_addr = AW'((32'(r_wr) + 32'(r_ki)) * 32'(IMG_W) + 32'(r_wc) + 32'(r_kj));
  assign o_w_addr   = KAW'(32'(r_ki) * 32'(K) + 32'(r_kj));
  assign o_row      = r_wr;
  assign o_col      = r_wc;
  assign o_first    = (r_ki == '0) && (r_kj == '0);
  assign o_last     = w_ki_end && w_kj_end;
  assign o_final    = w_ki_end && w_kj_end && w_wc_end && w_wr_end;

endmodule

// File: rtl/conv_tap_sequencer.sv
// Walks every KxK window of the image, issues tap reads, multiplies the
// returned operands and drives the downstream accumulator.
module conv_tap_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned K      = DEF_K,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PROD_W = DEF_PROD_W,
  localparam int unsigned AW    = clog2_min1(IMG_W * IMG_H),
  localparam int unsigned KAW   = clog2_min1(K * K),
  localparam int unsigned RW    = clog2_min1(IMG_H),
  localparam int unsigned CW    = clog2_min1(IMG_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [AW-1:0]     img_addr,
  input  logic [DATA_W-1:0] img_rdata,
  output logic [KAW-1:0]    w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              acc_en,
  output logic              acc_load,
  output logic [PROD_W-1:0] acc_data,
  output logic              result_valid,
  output logic [RW-1:0]     out_row,
  output logic [CW-1:0]     out_col,
  output logic              busy,
  output logic              done
);

  state_t r_state;
  state_t w_state_nxt;
  logic   [1:0] r_drain_cnt;
  logic   w_step;

  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_first;
  logic          w_last;
  logic          w_final;

  tag_t w_tag0;
  tag_t r_tag1;
  tag_t r_tag2;

  logic [2*DATA_W-1:0] w_prod;
  logic [PROD_W-1:0]   r_acc_data;
  logic                r_result_valid;
  logic                r_done;
  logic [RW-1:0]       r_out_row;
  logic [CW-1:0]       r_out_col;

  conv_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K)
  ) u_addr_gen (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_step     (w_step),
    .o_img_addr (img_addr),
    .o_w_addr   (w_addr),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_first    (w_first),
    .o_last     (w_last),
    .o_final    (w_final)
  );

  // State register and drain-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= (r_state == DRAIN && w_state_nxt == DRAIN) ? r_drain_cnt + 1'b1 : '0;
    end
  end

  // Next-state logic; one tap is stepped per cycle while issuing.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    unique case (r_state)
      IDLE:  if (start) w_state_nxt = ISSUE;
      ISSUE: begin
        w_step = 1'b1;
        if (w_final) w_state_nxt = DRAIN;
      end
      DRAIN: if (r_drain_cnt == 2'd2) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  // Stage-0 tag; flags are qualified by the step so idle cycles carry nothing.
  always_comb begin
    w_tag0       = '0;
    w_tag0.valid = w_step;
    w_tag0.first = w_step & w_first;
    w_tag0.last  = w_step & w_last;
    w_tag0.row   = COORD_W'(w_row);
    w_tag0.col   = COORD_W'(w_col);
  end

  assign w_prod = {{DATA_W{1'b0}}, img_rdata} * {{DATA_W{1'b0}}, w_rdata};

  // Tag pipeline alongside memory return, multiply and result flagging.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag1         <= '0;
      r_tag2         <= '0;
      r_acc_data     <= '0;
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
      r_out_row      <= '0;
      r_out_col      <= '0;
    end else begin
      r_tag1         <= w_tag0;
      r_tag2         <= r_tag1;
      r_acc_data     <= PROD_W'(w_prod);
      r_result_valid <= r_tag2.valid & r_tag2.last;
      r_done         <= r_tag2.valid & r_tag2.last &
                        (r_tag2.row == COORD_W'(IMG_H - K)) &
                        (r_tag2.col == COORD_W'(IMG_W - K));
      if (r_tag2.valid & r_tag2.last) begin
        r_out_row <= RW'(r_tag2.row);
        r_out_col <= CW'(r_tag2.col);
      end
    end
  end

  assign acc_en       = r_tag2.valid;
  assign acc_load     = r_tag2.first;
  assign acc_data     = r_acc_data;
  assign result_valid = r_result_valid;
  assign done         = r_done;
  assign out_row      = r_out_row;
  assign out_col      = r_out_col;

endmodule
